// File: rtl/vx_idx_mask_builder_pkg.sv
// -----------------------------------------------------------------------------
// vx_idx_mask_builder_pkg
// Shared helpers for the index-to-mask builder slice.
//   log2up(n) : index width needed to address n mask bits. It never returns less
//               than 1, so a one-bit mask still has a one-bit index port, and
//               index 1 then decodes as out of range.
// -----------------------------------------------------------------------------
package vx_idx_mask_builder_pkg;

    // Index width for an n-bit mask, clamped to at least one bit.
    function automatic int log2up(input int n);
        int w;
        if (n > 1) begin
            w = $clog2(n);
        end else begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/vx_idx_mask_builder_onehot.sv
// -----------------------------------------------------------------------------
// vx_idx_onehot
// Combinational decoder from a bit index to a one-hot mask bit.
//   REVERSE == 0 : index i selects bit N-1-i (leading-zero ordering)
//   REVERSE != 0 : index i selects bit i     (trailing-zero ordering)
// Ports:
//   in_idx  in  LOGN  bit index
//   onehot  out N     decoded bit; all zero when the index is out of range
//   err     out 1     index >= N
// -----------------------------------------------------------------------------
module vx_idx_onehot
    import vx_idx_mask_builder_pkg::*;
#(
    parameter int N       = 8,
    parameter int REVERSE = 0,
    parameter int LOGN    = log2up(N)
) (
    input  logic [LOGN-1:0] in_idx,
    output logic [N-1:0]    onehot,
    output logic            err
);

    logic [31:0] idx_ext_s;
    logic [31:0] bit_pos_s;

    // Widen the index so that range checks and the bit-position arithmetic
    // use the same width as the parameters.
    assign idx_ext_s = 32'(in_idx);

    // Range check, ordering selection and one-hot expansion. A bad index
    // yields an all-zero mask, so the caller can OR it in unconditionally.
    always_comb begin
        err       = 1'b0;
        bit_pos_s = 32'd0;
        onehot    = '0;
        if (idx_ext_s >= 32'(N)) begin
            err = 1'b1;
        end else begin
            if (REVERSE != 0) begin
                bit_pos_s = idx_ext_s;
            end else begin
                bit_pos_s = 32'(N - 1) - idx_ext_s;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!err && (bit_pos_s == 32'(i))) begin
                onehot[i] = 1'b1;
            end else begin
                onehot[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/vx_idx_mask_builder.sv
// -----------------------------------------------------------------------------
// vx_idx_mask_builder
// Rebuilds a bitmask from a serialized stream of bit indices. The block takes
// one index per cycle, ORs the decoded bit into an accumulator, and publishes
// the mask, its popcount and error flags when the beat marked last is accepted.
// Ports:
//   clk        in   1     clock
//   reset      in   1     synchronous reset, active low
//   in_valid   in   1     index beat valid
//   in_idx     in   LOGN  bit index
//   in_last    in   1     beat closes the packet
//   in_ready   out  1     beat accepted when in_valid && in_ready
//   out_valid  out  1     packet result valid
//   out_mask   out  N     accumulated mask
//   out_count  out  CNTW  distinct bits set in out_mask
//   out_dup    out  1     some index repeated an already-set bit
//   out_err    out  1     some index was >= N (its bit was ignored)
//   out_ready  in   1     result consumed when out_valid && out_ready
// -----------------------------------------------------------------------------
module vx_idx_mask_builder
    import vx_idx_mask_builder_pkg::*;
#(
    parameter int N       = 8,
    parameter int REVERSE = 0,
    parameter int LOGN    = log2up(N),
    parameter int CNTW    = $clog2(N + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [LOGN-1:0] in_idx,
    input  logic            in_last,
    output logic            in_ready,
    output logic            out_valid,
    output logic [N-1:0]    out_mask,
    output logic [CNTW-1:0] out_count,
    output logic            out_dup,
    output logic            out_err,
    input  logic            out_ready
);

    // Accumulator for the packet in flight
    logic [N-1:0]    acc_r;
    logic [CNTW-1:0] acc_cnt_r;
    logic            acc_dup_r;
    logic            acc_err_r;

    // Output register slice
    logic            out_valid_r;
    logic [N-1:0]    out_mask_r;
    logic [CNTW-1:0] out_count_r;
    logic            out_dup_r;
    logic            out_err_r;

    // Decode and next-state values
    logic [N-1:0]    onehot_s;
    logic            idx_err_s;
    logic            hit_s;
    logic            new_bit_s;
    logic            in_fire_s;
    logic            out_fire_s;
    logic [N-1:0]    nxt_mask_s;
    logic [CNTW-1:0] nxt_cnt_s;
    logic            nxt_dup_s;
    logic            nxt_err_s;

    vx_idx_onehot #(
        .N       (N),
        .REVERSE (REVERSE),
        .LOGN    (LOGN)
    ) u_onehot (
        .in_idx (in_idx),
        .onehot (onehot_s),
        .err    (idx_err_s)
    );

    // Ready depends only on the output slice, never on in_valid: a held result
    // stalls the input, so accumulation and holding never overlap.
    assign in_ready   = !out_valid_r || out_ready;
    assign in_fire_s  = in_valid && in_ready;
    assign out_fire_s = out_valid_r && out_ready;

    // An out-of-range index decodes to an all-zero one-hot, so hit_s is already
    // 0 then; only bits not yet set add to the count, which therefore stays <= N.
    assign hit_s      = |(acc_r & onehot_s);
    assign new_bit_s  = !idx_err_s && !hit_s;
    assign nxt_mask_s = acc_r | onehot_s;
    assign nxt_cnt_s  = acc_cnt_r + CNTW'(new_bit_s);
    assign nxt_dup_s  = acc_dup_r | (!idx_err_s && hit_s);
    assign nxt_err_s  = acc_err_r | idx_err_s;

    // Accumulate non-last beats; a last beat moves the result to the output
    // slice and clears the accumulator in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_r       <= '0;
            acc_cnt_r   <= '0;
            acc_dup_r   <= 1'b0;
            acc_err_r   <= 1'b0;
            out_mask_r  <= '0;
            out_count_r <= '0;
            out_dup_r   <= 1'b0;
            out_err_r   <= 1'b0;
        end else if (in_fire_s) begin
            if (in_last) begin
                out_mask_r  <= nxt_mask_s;
                out_count_r <= nxt_cnt_s;
                out_dup_r   <= nxt_dup_s;
                out_err_r   <= nxt_err_s;
                acc_r       <= '0;
                acc_cnt_r   <= '0;
                acc_dup_r   <= 1'b0;
                acc_err_r   <= 1'b0;
            end else begin
                acc_r       <= nxt_mask_s;
                acc_cnt_r   <= nxt_cnt_s;
                acc_dup_r   <= nxt_dup_s;
                acc_err_r   <= nxt_err_s;
            end
        end else begin
            acc_r <= acc_r;
        end
    end

    // Result valid: a new last beat wins over consumption, which lets one-beat
    // packets stream at full rate with out_valid held high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid_r <= 1'b0;
        end else if (in_fire_s && in_last) begin
            out_valid_r <= 1'b1;
        end else if (out_fire_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign out_valid = out_valid_r;
    assign out_mask  = out_mask_r;
    assign out_count = out_count_r;
    assign out_dup   = out_dup_r;
    assign out_err   = out_err_r;

endmodule

// File: tb/tb_vx_idx_mask_builder.sv
// -----------------------------------------------------------------------------
// tb_vx_idx_mask_builder
// Directed bench with three instances: A (N=8, leading order), B (N=8, trailing
// order) and C (N=6, trailing order, so indices 6 and 7 are out of range).
// Inputs change on the falling edge and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_vx_idx_mask_builder;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    // Instance A
    logic       a_in_valid, a_in_last, a_in_ready, a_out_valid, a_out_dup, a_out_err, a_out_ready;
    logic [2:0] a_in_idx;
    logic [7:0] a_out_mask;
    logic [3:0] a_out_count;
    // Instance B
    logic       b_in_valid, b_in_last, b_in_ready, b_out_valid, b_out_dup, b_out_err, b_out_ready;
    logic [2:0] b_in_idx;
    logic [7:0] b_out_mask;
    logic [3:0] b_out_count;
    // Instance C
    logic       c_in_valid, c_in_last, c_in_ready, c_out_valid, c_out_dup, c_out_err, c_out_ready;
    logic [2:0] c_in_idx;
    logic [5:0] c_out_mask;
    logic [2:0] c_out_count;

    vx_idx_mask_builder #(.N(8), .REVERSE(0)) u_a (
        .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_idx(a_in_idx), .in_last(a_in_last),
        .in_ready(a_in_ready), .out_valid(a_out_valid), .out_mask(a_out_mask),
        .out_count(a_out_count), .out_dup(a_out_dup), .out_err(a_out_err), .out_ready(a_out_ready)
    );

    vx_idx_mask_builder #(.N(8), .REVERSE(1)) u_b (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_idx(b_in_idx), .in_last(b_in_last),
        .in_ready(b_in_ready), .out_valid(b_out_valid), .out_mask(b_out_mask),
        .out_count(b_out_count), .out_dup(b_out_dup), .out_err(b_out_err), .out_ready(b_out_ready)
    );

    vx_idx_mask_builder #(.N(6), .REVERSE(1)) u_c (
        .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_idx(c_in_idx), .in_last(c_in_last),
        .in_ready(c_in_ready), .out_valid(c_out_valid), .out_mask(c_out_mask),
        .out_count(c_out_count), .out_dup(c_out_dup), .out_err(c_out_err), .out_ready(c_out_ready)
    );

    task automatic beat_a(input logic [2:0] idx, input logic last);
        @(negedge clk);
        a_in_valid = 1'b1; a_in_idx = idx; a_in_last = last;
        @(posedge clk);
    endtask

    task automatic beat_b(input logic [2:0] idx, input logic last);
        @(negedge clk);
        b_in_valid = 1'b1; b_in_idx = idx; b_in_last = last;
        @(posedge clk);
    endtask

    task automatic beat_c(input logic [2:0] idx, input logic last);
        @(negedge clk);
        c_in_valid = 1'b1; c_in_idx = idx; c_in_last = last;
        @(posedge clk);
    endtask

    task automatic drain();
        @(negedge clk);
        a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (a_out_valid !== 1'b0) begin fails++; $display("FAIL reset_a_valid got %0b want 0", a_out_valid); end
        checks++; if (a_out_mask !== 8'h00) begin fails++; $display("FAIL reset_a_mask got %b want 00000000", a_out_mask); end
        checks++; if (a_out_count !== 4'd0) begin fails++; $display("FAIL reset_a_count got %0d want 0", a_out_count); end
        checks++; if (a_in_ready !== 1'b1) begin fails++; $display("FAIL reset_a_ready got %0b want 1", a_in_ready); end
        checks++; if (b_out_valid !== 1'b0) begin fails++; $display("FAIL reset_b_valid got %0b want 0", b_out_valid); end
        checks++; if (c_out_mask !== 6'h00) begin fails++; $display("FAIL reset_c_mask got %b want 000000", c_out_mask); end
    endtask

    task automatic test_leading();
        beat_a(3'd0, 1'b0);
        beat_a(3'd3, 1'b0);
        beat_a(3'd7, 1'b1);
        @(negedge clk);
        a_in_valid = 1'b0;
        checks++; if (a_out_valid !== 1'b1) begin fails++; $display("FAIL lead_valid got %0b want 1", a_out_valid); end
        checks++; if (a_out_mask !== 8'b1001_0001) begin fails++; $display("FAIL lead_mask got %b want 10010001", a_out_mask); end
        checks++; if (a_out_count !== 4'd3) begin fails++; $display("FAIL lead_count got %0d want 3", a_out_count); end
        checks++; if (a_out_dup !== 1'b0 || a_out_err !== 1'b0) begin fails++; $display("FAIL lead_flags got dup=%0b err=%0b want 0 0", a_out_dup, a_out_err); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (a_out_valid !== 1'b0) begin fails++; $display("FAIL lead_consumed got %0b want 0", a_out_valid); end
    endtask

    task automatic test_trailing();
        beat_b(3'd0, 1'b0);
        beat_b(3'd3, 1'b0);
        beat_b(3'd7, 1'b1);
        @(negedge clk);
        b_in_valid = 1'b0;
        checks++; if (b_out_mask !== 8'b1000_1001) begin fails++; $display("FAIL trail_mask got %b want 10001001", b_out_mask); end
        checks++; if (b_out_count !== 4'd3) begin fails++; $display("FAIL trail_count got %0d want 3", b_out_count); end
        @(posedge clk);
        beat_b(3'd5, 1'b1);
        @(negedge clk);
        b_in_valid = 1'b0;
        checks++; if (b_out_valid !== 1'b1) begin fails++; $display("FAIL trail1_valid got %0b want 1", b_out_valid); end
        checks++; if (b_out_mask !== 8'b0010_0000) begin fails++; $display("FAIL trail1_mask got %b want 00100000", b_out_mask); end
        checks++; if (b_out_count !== 4'd1) begin fails++; $display("FAIL trail1_count got %0d want 1", b_out_count); end
        @(posedge clk);
    endtask

    task automatic test_dup();
        beat_a(3'd2, 1'b0);
        beat_a(3'd2, 1'b1);
        @(negedge clk);
        a_in_valid = 1'b0;
        checks++; if (a_out_mask !== 8'b0010_0000) begin fails++; $display("FAIL dup_mask got %b want 00100000", a_out_mask); end
        checks++; if (a_out_count !== 4'd1) begin fails++; $display("FAIL dup_count got %0d want 1", a_out_count); end
        checks++; if (a_out_dup !== 1'b1) begin fails++; $display("FAIL dup_flag got %0b want 1", a_out_dup); end
        @(posedge clk);
        beat_a(3'd1, 1'b1);
        @(negedge clk);
        a_in_valid = 1'b0;
        checks++; if (a_out_dup !== 1'b0) begin fails++; $display("FAIL dup_clear got %0b want 0", a_out_dup); end
        checks++; if (a_out_mask !== 8'b0100_0000) begin fails++; $display("FAIL dup_next_mask got %b want 01000000", a_out_mask); end
        @(posedge clk);
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        a_out_ready = 1'b0;
        beat_a(3'd3, 1'b1);
        @(negedge clk);
        // Offer the next packet while the result is held; it must wait.
        a_in_valid = 1'b1; a_in_idx = 3'd1; a_in_last = 1'b1;
        checks++; if (a_in_ready !== 1'b0) begin fails++; $display("FAIL bp_ready got %0b want 0", a_in_ready); end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            checks++; if (a_out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid[%0d] got %0b want 1", k, a_out_valid); end
            checks++; if (a_out_mask !== 8'b0001_0000) begin fails++; $display("FAIL bp_mask[%0d] got %b want 00010000", k, a_out_mask); end
            checks++; if (a_out_count !== 4'd1) begin fails++; $display("FAIL bp_count[%0d] got %0d want 1", k, a_out_count); end
            checks++; if (a_in_ready !== 1'b0) begin fails++; $display("FAIL bp_stall[%0d] got %0b want 0", k, a_in_ready); end
        end
        a_out_ready = 1'b1;
        #1;
        checks++; if (a_in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready got %0b want 1", a_in_ready); end
        @(posedge clk);
        @(negedge clk);
        a_in_valid = 1'b0;
        checks++; if (a_out_valid !== 1'b1) begin fails++; $display("FAIL bp_cont_valid got %0b want 1", a_out_valid); end
        checks++; if (a_out_mask !== 8'b0100_0000) begin fails++; $display("FAIL bp_new_mask got %b want 01000000", a_out_mask); end
        checks++; if (a_out_count !== 4'd1) begin fails++; $display("FAIL bp_new_count got %0d want 1", a_out_count); end
        @(posedge clk);
    endtask

    task automatic test_err();
        beat_c(3'd6, 1'b0);
        beat_c(3'd1, 1'b1);
        @(negedge clk);
        c_in_valid = 1'b0;
        checks++; if (c_out_mask !== 6'b00_0010) begin fails++; $display("FAIL err_mask got %b want 000010", c_out_mask); end
        checks++; if (c_out_count !== 3'd1) begin fails++; $display("FAIL err_count got %0d want 1", c_out_count); end
        checks++; if (c_out_err !== 1'b1) begin fails++; $display("FAIL err_flag got %0b want 1", c_out_err); end
        checks++; if (c_out_dup !== 1'b0) begin fails++; $display("FAIL err_dup got %0b want 0", c_out_dup); end
        @(posedge clk);
        beat_c(3'd7, 1'b1);
        @(negedge clk);
        c_in_valid = 1'b0;
        checks++; if (c_out_mask !== 6'b00_0000 || c_out_count !== 3'd0 || c_out_err !== 1'b1) begin
            fails++; $display("FAIL err_only got mask=%b count=%0d err=%0b want 000000 0 1", c_out_mask, c_out_count, c_out_err);
        end
        @(posedge clk);
    endtask

    task automatic test_midreset();
        beat_a(3'd4, 1'b0);
        beat_a(3'd5, 1'b0);
        @(negedge clk);
        a_in_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        checks++; if (a_out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %0b want 0", a_out_valid); end
        beat_a(3'd0, 1'b1);
        @(negedge clk);
        a_in_valid = 1'b0;
        checks++; if (a_out_mask !== 8'b1000_0000) begin fails++; $display("FAIL rst_mask got %b want 10000000", a_out_mask); end
        checks++; if (a_out_count !== 4'd1) begin fails++; $display("FAIL rst_count got %0d want 1", a_out_count); end
        @(posedge clk);
    endtask

    task automatic test_back_to_back();
        beat_a(3'd0, 1'b1);
        @(negedge clk);
        a_in_idx = 3'd1;
        checks++; if (a_out_valid !== 1'b1 || a_out_mask !== 8'b1000_0000) begin
            fails++; $display("FAIL b2b_0 got v=%0b mask=%b want 1 10000000", a_out_valid, a_out_mask);
        end
        @(posedge clk);
        @(negedge clk);
        a_in_idx = 3'd2;
        checks++; if (a_out_valid !== 1'b1 || a_out_mask !== 8'b0100_0000) begin
            fails++; $display("FAIL b2b_1 got v=%0b mask=%b want 1 01000000", a_out_valid, a_out_mask);
        end
        @(posedge clk);
        @(negedge clk);
        a_in_valid = 1'b0;
        checks++; if (a_out_valid !== 1'b1 || a_out_mask !== 8'b0010_0000 || a_out_count !== 4'd1) begin
            fails++; $display("FAIL b2b_2 got v=%0b mask=%b cnt=%0d want 1 00100000 1", a_out_valid, a_out_mask, a_out_count);
        end
        @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        a_in_valid = 1'b0; a_in_idx = 3'd0; a_in_last = 1'b0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_idx = 3'd0; b_in_last = 1'b0; b_out_ready = 1'b1;
        c_in_valid = 1'b0; c_in_idx = 3'd0; c_in_last = 1'b0; c_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        test_reset();
        test_leading();
        test_trailing();
        test_dup();
        test_backpressure();
        test_err();
        test_midreset();
        test_back_to_back();
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
